// File: rtl/hop_pkg.sv
// hop_pkg: shared types and constants for the hop kernel sequencer.
//   - hop_mode_e  : link state selecting the kernel operand recipe
//   - hop_state_e : sequencer FSM states
//   - kern_ops_t  : registered operand bundle presented to the kernel
//   - page_x()    : X operand for page / inquiry trains
package hop_pkg;

  localparam int unsigned NCH       = 79;
  localparam int unsigned N_MIN     = 20;
  localparam int unsigned KOFFSET_A = 24;
  localparam int unsigned KOFFSET_B = 8;
  localparam int unsigned ACC_W     = 8;   // mod-M accumulator width (M <= 79)
  localparam int unsigned CH_W      = 7;   // channel index / N width
  localparam int unsigned MAP_W     = 80;  // AFH channel map width
  localparam int unsigned ADDR_W    = 28;  // UAP[3:0]:LAP[23:0]

  typedef enum logic [2:0] {
    MODE_PAGE_SCAN = 3'd0,
    MODE_INQ_SCAN  = 3'd1,
    MODE_PAGE      = 3'd2,
    MODE_INQ       = 3'd3,
    MODE_CONN      = 3'd4
  } hop_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOD   = 2'd1,
    ST_APPLY = 2'd2,
    ST_CAPT  = 2'd3
  } hop_state_e;

  typedef struct packed {
    logic [4:0]       x;
    logic [4:0]       a;
    logic [3:0]       b;
    logic [4:0]       c;
    logic [8:0]       d;
    logic [CH_W-1:0]  e;
    logic [CH_W-1:0]  f;
    logic [CH_W-1:0]  fp;
    logic             y1;
    logic [5:0]       y2;
    logic [CH_W-1:0]  n;
    logic [MAP_W-1:0] map;
  } kern_ops_t;

  // X = (CLK16..12 + koffset + ((CLK4..2,0 - CLK16..12) mod 16)) mod 32
  function automatic logic [4:0] page_x(input logic [4:0] clk16_12,
                                        input logic [3:0] clk_lo,
                                        input logic       train_b);
    logic [3:0] diff;
    logic [4:0] koff;
    koff = train_b ? 5'(KOFFSET_B) : 5'(KOFFSET_A);
    diff = clk_lo - clk16_12[3:0];
    return 5'(clk16_12 + koff + {1'b0, diff});
  endfunction

endpackage

// File: rtl/hop_modacc.sv
// hop_modacc: bit-serial mod-M accumulator, r <= (2r + serial_bit) mod m.
//   clk, rst    : clock, synchronous active-high reset
//   init        : clear the residue to 0
//   step        : perform one MSB-first iteration
//   serial_bit  : next input bit (0 for the trailing doubling steps)
//   m           : modulus, 1..79
//   r           : current residue
module hop_modacc
  import hop_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             step,
  input  logic             serial_bit,
  input  logic [ACC_W-1:0] m,
  output logic [CH_W-1:0]  r
);

  logic [ACC_W-1:0] r_q;
  logic [ACC_W:0]   dbl_c;

  // r < m, so 2r+bit < 2m and a single compare-subtract reduces it
  assign dbl_c = {r_q, serial_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (init) begin
      r_q <= '0;
    end else if (step) begin
      r_q <= ACC_W'((dbl_c >= {1'b0, m}) ? (dbl_c - {1'b0, m}) : dbl_c);
    end
  end

  assign r = CH_W'(r_q);

endmodule

// File: rtl/hop_ctrl.sv
// hop_ctrl: sequencer for the external hop selection kernel. Snapshots clock
// and address on start, derives F / F' serially (connection state only),
// registers the kernel operands, then captures the kernel result.
//   clk, rst         : clock, synchronous active-high reset
//   start            : request pulse, honoured only while idle
//   mode, train_b    : link state and page/inquiry train select
//   clk_in, addr     : clock snapshot source and device address
//   afh_en, afh_n    : adapted hopping enable and used-channel count
//   afh_map          : used-channel map (not latched; hold through capture)
//   fk_in            : kernel result
//   kern_*           : registered kernel operands and AFH configuration
//   busy             : request in progress
//   fk_out, fk_valid : captured channel and its one-cycle qualifier
//   cfg_err          : sticky illegal-mode / bad-AFH flag
module hop_ctrl
  import hop_pkg::*;
#(
  parameter int unsigned CLK_W    = 28,
  parameter int unsigned MOD_BITS = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic              train_b,
  input  logic [CLK_W-1:0]  clk_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              afh_en,
  input  logic [CH_W-1:0]   afh_n,
  input  logic [MAP_W-1:0]  afh_map,
  input  logic [CH_W-1:0]   fk_in,
  output logic [4:0]        kern_x,
  output logic [4:0]        kern_a,
  output logic [3:0]        kern_b,
  output logic [4:0]        kern_c,
  output logic [8:0]        kern_d,
  output logic [CH_W-1:0]   kern_e,
  output logic [CH_W-1:0]   kern_f,
  output logic [CH_W-1:0]   kern_fp,
  output logic              kern_y1,
  output logic [5:0]        kern_y2,
  output logic [CH_W-1:0]   kern_n,
  output logic [MAP_W-1:0]  kern_map,
  output logic              busy,
  output logic [CH_W-1:0]   fk_out,
  output logic              fk_valid,
  output logic              cfg_err
);

  localparam int unsigned ITERS     = MOD_BITS + 4;
  localparam int unsigned CNT_W     = $clog2(ITERS);
  localparam int unsigned OPS_CLK_W = 26;  // CLK25..0 feed the operands

  hop_state_e             state_q, state_c;
  hop_mode_e              mode_q, mode_in_c;
  logic                   train_q;
  logic [OPS_CLK_W-1:0]   clk_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   adapt_q;
  logic [CH_W-1:0]        n_eff_q;
  logic [MOD_BITS-1:0]    sh_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   accept_c, step_c, load_c, capt_c;
  logic                   mode_bad_c, n_ok_c, is_conn_c, is_scan_c;
  logic [CH_W-1:0]        acc_f, acc_fp;
  kern_ops_t              kern_q, ops_c;

  // Request decode: illegal modes fall back to page scan
  assign mode_bad_c = (mode > 3'(MODE_CONN));
  assign mode_in_c  = mode_bad_c ? MODE_PAGE_SCAN : hop_mode_e'(mode);
  assign n_ok_c     = (afh_n >= CH_W'(N_MIN)) && (afh_n <= CH_W'(NCH));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_c;
    end
  end

  // FSM next state
  always_comb begin
    state_c = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_c = (mode_in_c == MODE_CONN) ? ST_MOD : ST_APPLY;
        end
      end
      ST_MOD: begin
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_c = ST_APPLY;
        end
      end
      ST_APPLY: state_c = ST_CAPT;
      ST_CAPT:  state_c = ST_IDLE;
      default:  state_c = ST_IDLE;
    endcase
  end

  // FSM control strobes
  always_comb begin
    accept_c = 1'b0;
    step_c   = 1'b0;
    load_c   = 1'b0;
    capt_c   = 1'b0;
    case (state_q)
      ST_IDLE:  accept_c = start;
      ST_MOD:   step_c   = 1'b1;
      ST_APPLY: load_c   = 1'b1;
      ST_CAPT:  capt_c   = 1'b1;
      default:  ;
    endcase
  end

  // F = 16*CLK27..7 mod 79 and F' = 16*CLK27..7 mod N, in parallel
  hop_modacc u_acc_f (
    .clk        (clk),
    .rst        (rst),
    .init       (accept_c),
    .step       (step_c),
    .serial_bit (sh_q[MOD_BITS-1]),
    .m          (ACC_W'(NCH)),
    .r          (acc_f)
  );

  hop_modacc u_acc_fp (
    .clk        (clk),
    .rst        (rst),
    .init       (accept_c),
    .step       (step_c),
    .serial_bit (sh_q[MOD_BITS-1]),
    .m          ({1'b0, n_eff_q}),
    .r          (acc_fp)
  );

  // Operand recipe for the latched link state
  assign is_conn_c = (mode_q == MODE_CONN);
  assign is_scan_c = (mode_q == MODE_PAGE_SCAN) || (mode_q == MODE_INQ_SCAN);

  always_comb begin
    ops_c   = '0;
    ops_c.a = addr_q[27:23] ^ (is_conn_c ? clk_q[25:21] : 5'd0);
    ops_c.b = addr_q[22:19];
    ops_c.c = {addr_q[8], addr_q[6], addr_q[4], addr_q[2], addr_q[0]}
              ^ (is_conn_c ? clk_q[20:16] : 5'd0);
    ops_c.d = addr_q[18:10] ^ (is_conn_c ? clk_q[15:7] : 9'd0);
    ops_c.e = {addr_q[13], addr_q[11], addr_q[9], addr_q[7],
               addr_q[5], addr_q[3], addr_q[1]};
    if (is_conn_c) begin
      ops_c.x = clk_q[6:2];
    end else if (is_scan_c) begin
      ops_c.x = clk_q[16:12];
    end else begin
      ops_c.x = page_x(clk_q[16:12], {clk_q[4:2], clk_q[0]}, train_q);
    end
    ops_c.f   = is_conn_c ? acc_f  : '0;
    ops_c.fp  = is_conn_c ? acc_fp : '0;
    ops_c.y1  = is_scan_c ? 1'b0 : clk_q[1];
    ops_c.y2  = {ops_c.y1, 5'd0};
    ops_c.n   = adapt_q ? n_eff_q : CH_W'(NCH);
    ops_c.map = adapt_q ? afh_map : '1;
  end

  // Request snapshot, iteration tracking, operand and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_PAGE_SCAN;
      train_q    <= 1'b0;
      clk_q      <= '0;
      addr_q     <= '0;
      adapt_q    <= 1'b0;
      n_eff_q    <= CH_W'(NCH);
      sh_q       <= '0;
      cnt_q      <= '0;
      kern_q     <= '0;
      kern_q.n   <= CH_W'(NCH);
      kern_q.map <= '1;
      busy       <= 1'b0;
      fk_out     <= '0;
      fk_valid   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      fk_valid <= 1'b0;
      if (accept_c) begin
        mode_q  <= mode_in_c;
        train_q <= train_b;
        clk_q   <= clk_in[OPS_CLK_W-1:0];
        addr_q  <= addr;
        adapt_q <= afh_en && n_ok_c && (mode_in_c == MODE_CONN);
        n_eff_q <= (afh_en && n_ok_c && (mode_in_c == MODE_CONN)) ? afh_n
                                                                  : CH_W'(NCH);
        sh_q    <= clk_in[CLK_W-1 -: MOD_BITS];
        cnt_q   <= '0;
        busy    <= 1'b1;
        cfg_err <= mode_bad_c || (afh_en && !n_ok_c);
      end
      if (step_c) begin
        // zeros shift in behind CLK7, giving the trailing doubling steps
        sh_q  <= {sh_q[MOD_BITS-2:0], 1'b0};
        cnt_q <= CNT_W'(cnt_q + 1'b1);
      end
      if (load_c) begin
        kern_q <= ops_c;
      end
      if (capt_c) begin
        fk_out   <= fk_in;
        fk_valid <= 1'b1;
        busy     <= 1'b0;
      end
    end
  end

  assign kern_x   = kern_q.x;
  assign kern_a   = kern_q.a;
  assign kern_b   = kern_q.b;
  assign kern_c   = kern_q.c;
  assign kern_d   = kern_q.d;
  assign kern_e   = kern_q.e;
  assign kern_f   = kern_q.f;
  assign kern_fp  = kern_q.fp;
  assign kern_y1  = kern_q.y1;
  assign kern_y2  = kern_q.y2;
  assign kern_n   = kern_q.n;
  assign kern_map = kern_q.map;

endmodule

// File: tb/tb_hop_ctrl.sv
// tb_hop_ctrl: directed bench for hop_ctrl. Inputs change on the falling edge,
// outputs are sampled on the falling edge; cycle 0 is the start cycle.
module tb_hop_ctrl;

  logic        clk, rst, start, train_b, afh_en;
  logic [2:0]  mode;
  logic [27:0] clk_in, addr;
  logic [6:0]  afh_n, fk_in;
  logic [79:0] afh_map;
  logic [4:0]  kern_x, kern_a, kern_c;
  logic [3:0]  kern_b;
  logic [8:0]  kern_d;
  logic [6:0]  kern_e, kern_f, kern_fp, kern_n, fk_out;
  logic        kern_y1;
  logic [5:0]  kern_y2;
  logic [79:0] kern_map;
  logic        busy, fk_valid, cfg_err;

  int checks   = 0;
  int failures = 0;

  logic [79:0] ones80 = '1;
  logic [79:0] map1   = 80'hA5A5_0F0F_1234_5678_9ABC;

  hop_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .train_b(train_b),
    .clk_in(clk_in), .addr(addr), .afh_en(afh_en), .afh_n(afh_n),
    .afh_map(afh_map), .fk_in(fk_in),
    .kern_x(kern_x), .kern_a(kern_a), .kern_b(kern_b), .kern_c(kern_c),
    .kern_d(kern_d), .kern_e(kern_e), .kern_f(kern_f), .kern_fp(kern_fp),
    .kern_y1(kern_y1), .kern_y2(kern_y2), .kern_n(kern_n), .kern_map(kern_map),
    .busy(busy), .fk_out(fk_out), .fk_valid(fk_valid), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request in cycle 0; returns at the falling edge of cycle 1
  task automatic issue(input logic [2:0] m, input logic tb_sel,
                       input logic [27:0] c, input logic [27:0] a,
                       input logic ae, input logic [6:0] n);
    @(negedge clk);
    mode = m; train_b = tb_sel; clk_in = c; addr = a; afh_en = ae; afh_n = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for fk_valid; cyc is the request cycle it was seen in
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (fk_valid !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (fk_valid !== 1'b0) begin failures++; $display("FAIL reset_fk_valid got=%0h exp=0", fk_valid); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%0h exp=0", cfg_err); end
    checks++; if (fk_out !== 7'd0) begin failures++; $display("FAIL reset_fk_out got=%0h exp=0", fk_out); end
    checks++; if ({kern_x, kern_a, kern_b, kern_c, kern_d, kern_e, kern_f, kern_fp, kern_y1, kern_y2} !== 63'd0) begin
      failures++; $display("FAIL reset_ops got=%0h exp=0", {kern_x, kern_a, kern_b, kern_c, kern_d, kern_e, kern_f, kern_fp, kern_y1, kern_y2});
    end
    checks++; if (kern_n !== 7'd79) begin failures++; $display("FAIL reset_kern_n got=%0d exp=79", kern_n); end
    checks++; if (kern_map !== ones80) begin failures++; $display("FAIL reset_kern_map got=%0h exp=%0h", kern_map, ones80); end
    rst = 1'b0;
  endtask

  task automatic test_conn_basic();
    int cyc;
    fk_in = 7'h2A;
    issue(3'd4, 1'b0, 28'h0, 28'h0, 1'b0, 7'd0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL conn0_busy got=%0h exp=1", busy); end
    wait_valid(cyc);
    checks++; if (cyc != 28) begin failures++; $display("FAIL conn0_latency got=%0d exp=28", cyc); end
    checks++; if (fk_out !== 7'h2A) begin failures++; $display("FAIL conn0_fk_out got=%0h exp=2a", fk_out); end
    checks++; if ({kern_x, kern_a, kern_b, kern_c, kern_d, kern_e, kern_f, kern_fp, kern_y1, kern_y2} !== 63'd0) begin
      failures++; $display("FAIL conn0_ops got=%0h exp=0", {kern_x, kern_a, kern_b, kern_c, kern_d, kern_e, kern_f, kern_fp, kern_y1, kern_y2});
    end
    checks++; if (kern_n !== 7'd79) begin failures++; $display("FAIL conn0_kern_n got=%0d exp=79", kern_n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL conn0_busy_clr got=%0h exp=0", busy); end
    @(negedge clk);
    checks++; if (fk_valid !== 1'b0) begin failures++; $display("FAIL conn0_pulse_width got=%0h exp=0", fk_valid); end
  endtask

  task automatic test_conn_afh();
    int cyc;
    afh_map = map1;
    // CLK27..7 = 5, N = 20: F = 80 mod 79 = 1, F' = 80 mod 20 = 0
    issue(3'd4, 1'b0, 28'h280, 28'h0, 1'b1, 7'd20);
    wait_valid(cyc);
    checks++; if (cyc != 28) begin failures++; $display("FAIL afh20_latency got=%0d exp=28", cyc); end
    checks++; if (kern_f !== 7'd1) begin failures++; $display("FAIL afh20_f got=%0d exp=1", kern_f); end
    checks++; if (kern_fp !== 7'd0) begin failures++; $display("FAIL afh20_fp got=%0d exp=0", kern_fp); end
    checks++; if (kern_n !== 7'd20) begin failures++; $display("FAIL afh20_n got=%0d exp=20", kern_n); end
    checks++; if (kern_map !== map1) begin failures++; $display("FAIL afh20_map got=%0h exp=%0h", kern_map, map1); end
    checks++; if (kern_d !== 9'd5) begin failures++; $display("FAIL afh20_d got=%0h exp=5", kern_d); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL afh20_cfg_err got=%0h exp=0", cfg_err); end
    // CLK27..7 = 1, N = 79, address all ones: F = F' = 16, operands mixed
    issue(3'd4, 1'b0, 28'h80, 28'hFFFFFFF, 1'b1, 7'd79);
    wait_valid(cyc);
    checks++; if (kern_f !== 7'd16) begin failures++; $display("FAIL afh79_f got=%0d exp=16", kern_f); end
    checks++; if (kern_fp !== 7'd16) begin failures++; $display("FAIL afh79_fp got=%0d exp=16", kern_fp); end
    checks++; if (kern_n !== 7'd79) begin failures++; $display("FAIL afh79_n got=%0d exp=79", kern_n); end
    checks++; if ({kern_a, kern_b, kern_c} !== 14'h3FFF) begin failures++; $display("FAIL afh79_abc got=%0h exp=3fff", {kern_a, kern_b, kern_c}); end
    checks++; if (kern_d !== 9'h1FE) begin failures++; $display("FAIL afh79_d got=%0h exp=1fe", kern_d); end
    checks++; if (kern_e !== 7'h7F) begin failures++; $display("FAIL afh79_e got=%0h exp=7f", kern_e); end
    // CLK27..7 = 100, N = 37: F = 1600 mod 79 = 20, F' = 1600 mod 37 = 9
    issue(3'd4, 1'b0, 28'h327E, 28'h0, 1'b1, 7'd37);
    wait_valid(cyc);
    checks++; if (kern_f !== 7'd20) begin failures++; $display("FAIL afh37_f got=%0d exp=20", kern_f); end
    checks++; if (kern_fp !== 7'd9) begin failures++; $display("FAIL afh37_fp got=%0d exp=9", kern_fp); end
    checks++; if (kern_x !== 5'd31) begin failures++; $display("FAIL afh37_x got=%0d exp=31", kern_x); end
    checks++; if ({kern_y1, kern_y2} !== 7'h60) begin failures++; $display("FAIL afh37_y got=%0h exp=60", {kern_y1, kern_y2}); end
    checks++; if (kern_d !== 9'd100) begin failures++; $display("FAIL afh37_d got=%0d exp=100", kern_d); end
  endtask

  task automatic test_page();
    int cyc;
    fk_in = 7'h11;
    issue(3'd2, 1'b0, 28'h1F000, 28'hF800000, 1'b0, 7'd0);
    wait_valid(cyc);
    checks++; if (cyc != 3) begin failures++; $display("FAIL pageA_latency got=%0d exp=3", cyc); end
    checks++; if (kern_x !== 5'd24) begin failures++; $display("FAIL pageA_x got=%0d exp=24", kern_x); end
    checks++; if (kern_a !== 5'd31) begin failures++; $display("FAIL pageA_a got=%0d exp=31", kern_a); end
    checks++; if ({kern_f, kern_fp} !== 14'd0) begin failures++; $display("FAIL pageA_ffp got=%0h exp=0", {kern_f, kern_fp}); end
    checks++; if (kern_n !== 7'd79) begin failures++; $display("FAIL pageA_n got=%0d exp=79", kern_n); end
    checks++; if (kern_map !== ones80) begin failures++; $display("FAIL pageA_map got=%0h exp=%0h", kern_map, ones80); end
    checks++; if (fk_out !== 7'h11) begin failures++; $display("FAIL pageA_fk_out got=%0h exp=11", fk_out); end
    issue(3'd2, 1'b1, 28'h1F002, 28'hF800000, 1'b0, 7'd0);
    wait_valid(cyc);
    checks++; if (cyc != 3) begin failures++; $display("FAIL pageB_latency got=%0d exp=3", cyc); end
    checks++; if (kern_x !== 5'd8) begin failures++; $display("FAIL pageB_x got=%0d exp=8", kern_x); end
    checks++; if ({kern_y1, kern_y2} !== 7'h60) begin failures++; $display("FAIL pageB_y got=%0h exp=60", {kern_y1, kern_y2}); end
    issue(3'd0, 1'b0, 28'h1F002, 28'hF800000, 1'b0, 7'd0);
    wait_valid(cyc);
    checks++; if (cyc != 3) begin failures++; $display("FAIL pscan_latency got=%0d exp=3", cyc); end
    checks++; if (kern_x !== 5'd31) begin failures++; $display("FAIL pscan_x got=%0d exp=31", kern_x); end
    checks++; if ({kern_y1, kern_y2} !== 7'h00) begin failures++; $display("FAIL pscan_y got=%0h exp=0", {kern_y1, kern_y2}); end
    checks++; if (kern_a !== 5'd31) begin failures++; $display("FAIL pscan_a got=%0d exp=31", kern_a); end
  endtask

  task automatic test_illegal_mode();
    int cyc;
    issue(3'd6, 1'b1, 28'h1F002, 28'h0, 1'b0, 7'd0);
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL illegal_cfg_err got=%0h exp=1", cfg_err); end
    wait_valid(cyc);
    checks++; if (cyc != 3) begin failures++; $display("FAIL illegal_latency got=%0d exp=3", cyc); end
    checks++; if (kern_x !== 5'd31) begin failures++; $display("FAIL illegal_x got=%0d exp=31", kern_x); end
    checks++; if (kern_y1 !== 1'b0) begin failures++; $display("FAIL illegal_y1 got=%0h exp=0", kern_y1); end
    issue(3'd2, 1'b0, 28'h1F000, 28'h0, 1'b0, 7'd0);
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL illegal_err_clear got=%0h exp=0", cfg_err); end
    wait_valid(cyc);
  endtask

  task automatic test_bad_afh();
    int cyc, pulses, first;
    logic [4:0] x_at_valid;
    afh_map = map1;
    pulses = 0; first = 0; x_at_valid = '1;
    issue(3'd4, 1'b0, 28'h80, 28'h0, 1'b1, 7'd15);
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL badafh_cfg_err got=%0h exp=1", cfg_err); end
    cyc = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin
        mode = 3'd2; clk_in = 28'h0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (fk_valid === 1'b1) begin
        pulses++;
        if (first == 0) begin
          first = cyc;
          x_at_valid = kern_x;
          checks++; if (kern_n !== 7'd79) begin failures++; $display("FAIL badafh_n got=%0d exp=79", kern_n); end
          checks++; if (kern_map !== ones80) begin failures++; $display("FAIL badafh_map got=%0h exp=%0h", kern_map, ones80); end
          checks++; if ({kern_f, kern_fp} !== {7'd16, 7'd16}) begin failures++; $display("FAIL badafh_ffp got=%0h exp=810", {kern_f, kern_fp}); end
        end
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL ignored_start_pulses got=%0d exp=1", pulses); end
    checks++; if (first != 28) begin failures++; $display("FAIL ignored_start_latency got=%0d exp=28", first); end
    checks++; if (x_at_valid !== 5'd0) begin failures++; $display("FAIL ignored_start_x got=%0d exp=0", x_at_valid); end
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL badafh_sticky got=%0h exp=1", cfg_err); end
  endtask

  task automatic test_reset_mid();
    int cyc, pulses;
    pulses = 0;
    issue(3'd4, 1'b0, 28'h80, 28'h0, 1'b0, 7'd0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0h exp=0", busy); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL midrst_cfg_err got=%0h exp=0", cfg_err); end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fk_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL midrst_no_valid got=%0d exp=0", pulses); end
    issue(3'd2, 1'b0, 28'h1F000, 28'h0, 1'b0, 7'd0);
    wait_valid(cyc);
    checks++; if (cyc != 3) begin failures++; $display("FAIL midrst_next_latency got=%0d exp=3", cyc); end
    checks++; if (kern_x !== 5'd24) begin failures++; $display("FAIL midrst_next_x got=%0d exp=24", kern_x); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    fk_in = 7'h33;
    issue(3'd2, 1'b0, 28'h1F000, 28'h0, 1'b0, 7'd0);
    wait_valid(cyc);
    checks++; if (fk_out !== 7'h33) begin failures++; $display("FAIL b2b_first_fk got=%0h exp=33", fk_out); end
    // new request in the fk_valid cycle
    mode = 3'd2; train_b = 1'b1; clk_in = 28'h1F002; start = 1'b1;
    fk_in = 7'h44;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%0h exp=1", busy); end
    checks++; if (fk_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop got=%0h exp=0", fk_valid); end
    wait_valid(cyc);
    checks++; if (cyc != 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=3", cyc); end
    checks++; if (kern_x !== 5'd8) begin failures++; $display("FAIL b2b_x got=%0d exp=8", kern_x); end
    checks++; if (fk_out !== 7'h44) begin failures++; $display("FAIL b2b_fk got=%0h exp=44", fk_out); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 3'd0; train_b = 1'b0; clk_in = '0;
    addr = '0; afh_en = 1'b0; afh_n = '0; afh_map = '0; fk_in = '0;
    test_reset();
    test_conn_basic();
    test_conn_afh();
    test_page();
    test_illegal_mode();
    test_bad_afh();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
